decode_div_63s_24ns_40_seq: RTL and testbench

- Multi-cycle signed-by-unsigned divider for the decoder path. It is the inverse of the encoder's pipelined 40s×24ns→63 multiplier stage.
- Takes a 63-bit signed product-domain value and a 24-bit unsigned scale. Returns a 40-bit signed quotient and a signed remainder.
- Uses a radix-2 restoring iteration with a start/done handshake and ce-qualified stalling. Sits between the decode accumulator and the feature-map reconstruction buffer.

---
 rtl/decode_div_63s_24ns_40_seq.sv | 204 ++++++++++++++++++++
 tb/tb_decode_div_63s_24ns_40_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_div_63s_24ns_40_seq.sv
// ----------------------------------------------------------------------------
// decode_div_63s_24ns_40_seq
//
// Multi-cycle signed-by-unsigned divider for the decoder path. This is the
// inverse of the encoder's 40s x 24ns -> 63 multiplier stage. The divider takes
// a signed dividend (din0) and an unsigned divisor (din1). It produces a
// quotient truncated toward zero and saturated to dout_WIDTH bits. It also
// produces a remainder whose sign follows the dividend.
//
// Each accepted operation passes through three states:
//   IDLE -> CALC (din0_WIDTH restoring steps) -> FIX (sign/saturate/register).
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset, wins over ce and start
//   ce     : clock enable, all registers hold when low
//   start  : request, sampled only in IDLE with ce=1
//   din0   : signed dividend, captured on an accepted start
//   din1   : unsigned divisor, captured on an accepted start
//   busy   : high from the cycle after an accepted start until done
//   done   : one-cycle (ce-qualified) pulse; result outputs are valid
//   dout   : signed quotient
//   rem    : signed remainder (din1_WIDTH+1 bits)
//   div0   : divisor was zero
//   ovf    : quotient saturated
// ----------------------------------------------------------------------------
module decode_div_63s_24ns_40_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 63,
  parameter int din1_WIDTH = 24,
  parameter int dout_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  div0,
  output logic                  ovf
);

  // ID is an instance tag only; it is folded in here so that it is referenced.
  localparam int CNT_W = $clog2(din0_WIDTH) + (ID * 0);
  localparam int PR_W  = din1_WIDTH + 1;

  // Quotient magnitude limits, expressed at dividend width.
  localparam logic [din0_WIDTH-1:0] NEG_LIM =
    {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic [din0_WIDTH-1:0] POS_LIM =
    NEG_LIM - {{(din0_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negate at quotient width.
  function automatic logic [dout_WIDTH-1:0] neg_q(input logic [dout_WIDTH-1:0] v);
    neg_q = ~v + {{(dout_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negate at remainder width.
  function automatic logic [PR_W-1:0] neg_r(input logic [PR_W-1:0] v);
    neg_r = ~v + {{(PR_W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of the signed dividend. The most negative value maps exactly to
  // 2^(din0_WIDTH-1) because the result is read as unsigned.
  function automatic logic [din0_WIDTH-1:0] abs_d(input logic [din0_WIDTH-1:0] v);
    if (v[din0_WIDTH-1]) begin
      abs_d = ~v + {{(din0_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_d = v;
    end
  endfunction

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   sign_r;
  // Holds the dividend magnitude at first. Quotient bits shift in at the LSB,
  // so after the last step this register holds the unsigned quotient.
  logic [din0_WIDTH-1:0]  mag_r;
  logic [din1_WIDTH-1:0]  d_r;
  logic [PR_W-1:0]        pr_r;

  logic [PR_W-1:0]        shifted_s;
  logic [PR_W:0]          trial_s;
  logic [PR_W-1:0]        pr_next_s;
  logic [din0_WIDTH-1:0]  mag_next_s;

  logic [dout_WIDTH-1:0]  dout_fix_s;
  logic [PR_W-1:0]        rem_fix_s;
  logic                   div0_fix_s;
  logic                   ovf_fix_s;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted_s  = {pr_r[din1_WIDTH-1:0], mag_r[din0_WIDTH-1]};
    trial_s    = {1'b0, shifted_s} - {2'b00, d_r};
    pr_next_s  = shifted_s;
    mag_next_s = {mag_r[din0_WIDTH-2:0], 1'b0};
    if (!trial_s[PR_W]) begin
      pr_next_s  = trial_s[PR_W-1:0];
      mag_next_s = {mag_r[din0_WIDTH-2:0], 1'b1};
    end else begin
      pr_next_s  = shifted_s;
    end
  end

  // Result shaping: divide-by-zero override, sign application, saturation.
  always_comb begin
    dout_fix_s = {dout_WIDTH{1'b0}};
    rem_fix_s  = {PR_W{1'b0}};
    div0_fix_s = 1'b0;
    ovf_fix_s  = 1'b0;
    if (d_r == {din1_WIDTH{1'b0}}) begin
      div0_fix_s = 1'b1;
      dout_fix_s = sign_r ? Q_MIN : Q_MAX;
    end else if (!sign_r) begin
      rem_fix_s = pr_r;
      if (mag_r > POS_LIM) begin
        dout_fix_s = Q_MAX;
        ovf_fix_s  = 1'b1;
      end else begin
        dout_fix_s = mag_r[dout_WIDTH-1:0];
      end
    end else begin
      rem_fix_s = neg_r(pr_r);
      // A magnitude of exactly 2^(dout_WIDTH-1) is representable when negative.
      if (mag_r > NEG_LIM) begin
        dout_fix_s = Q_MIN;
        ovf_fix_s  = 1'b1;
      end else begin
        dout_fix_s = neg_q(mag_r[dout_WIDTH-1:0]);
      end
    end
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sign_r  <= 1'b0;
      mag_r   <= {din0_WIDTH{1'b0}};
      d_r     <= {din1_WIDTH{1'b0}};
      pr_r    <= {PR_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= {dout_WIDTH{1'b0}};
      rem     <= {PR_W{1'b0}};
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else if (ce) begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_r  <= din0[din0_WIDTH-1];
            mag_r   <= abs_d(din0);
            d_r     <= din1;
            pr_r    <= {PR_W{1'b0}};
            cnt_r   <= CNT_W'(din0_WIDTH - 1);
            busy    <= 1'b1;
            state_r <= CALC;
          end
        end
        CALC: begin
          pr_r  <= pr_next_s;
          mag_r <= mag_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          dout    <= dout_fix_s;
          rem     <= rem_fix_s;
          div0    <= div0_fix_s;
          ovf     <= ovf_fix_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_div_63s_24ns_40_seq.sv
// Directed testbench for decode_div_63s_24ns_40_seq.
module tb_decode_div_63s_24ns_40_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [62:0] din0;
  logic [23:0] din1;
  logic        busy;
  logic        done;
  logic [39:0] dout;
  logic [24:0] rem;
  logic        div0;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] QMAX = 40'h7F_FFFF_FFFF;
  localparam logic [39:0] QMIN = 40'h80_0000_0000;

  always #5 clk = ~clk;

  decode_div_63s_24ns_40_seq #(
    .ID(1), .din0_WIDTH(63), .din1_WIDTH(24), .dout_WIDTH(40)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout(dout), .rem(rem),
    .div0(div0), .ovf(ovf)
  );

  // Issue one operation from a negedge. lat counts cycles from the start cycle
  // to the cycle done is seen (the start cycle counts as 1). The run can stall
  // ce for stall_len edges from stall_at. It can also poke a spurious start at
  // poke_at.
  task automatic run_op(input logic [62:0] a, input logic [23:0] b,
                        input int stall_at, input int stall_len, input int poke_at,
                        output int lat, output int busy_cnt);
    din0 = a; din1 = b; start = 1'b1; ce = 1'b1;
    @(posedge clk);
    lat = 1; busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      ce = (lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (lat == poke_at) begin
        start = 1'b1; din0 = 63'd12345; din1 = 24'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    ce = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = 63'd0; din1 = 24'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, div0, ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div0, ovf});
    end
    checks++;
    if (dout !== 40'd0 || rem !== 25'd0) begin
      errors++; $display("FAIL reset_data: dout=%h rem=%h want 0", dout, rem);
    end
  endtask

  task automatic test_positive;
    int lat, bc;
    run_op(63'd1000, 24'd7, 1000, 0, -1, lat, bc);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL pos_latency: got %0d want 65", lat); end
    checks++;
    if (bc !== 64) begin errors++; $display("FAIL pos_busy_cycles: got %0d want 64", bc); end
    checks++;
    if (dout !== 40'd142 || rem !== 25'd6 || div0 !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL pos_result: dout=%0d rem=%0d div0=%b ovf=%b want 142 6 0 0", dout, rem, div0, ovf);
    end
  endtask

  task automatic test_negative_back_to_back;
    int lat, bc;
    run_op(-63'sd1000, 24'd7, 1000, 0, -1, lat, bc);
    checks++;
    if (dout !== -40'sd142 || rem !== -25'sd6 || ovf !== 1'b0) begin
      errors++; $display("FAIL neg_result: dout=%h rem=%h ovf=%b want -142 -6 0", dout, rem, ovf);
    end
    // Starts on the very cycle done is high.
    run_op(63'h4000_0000_0000_0000, 24'h80_0000, 1000, 0, -1, lat, bc);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL b2b_latency: got %0d want 65", lat); end
    checks++;
    if (dout !== QMIN || rem !== 25'd0 || ovf !== 1'b0 || div0 !== 1'b0) begin
      errors++; $display("FAIL b2b_min_exact: dout=%h rem=%h ovf=%b want %h 0 0", dout, rem, ovf, QMIN);
    end
  endtask

  task automatic test_overflow;
    logic [62:0] a  [6];
    logic [23:0] b  [6];
    logic [39:0] eq [6];
    logic [24:0] er [6];
    logic        eo [6];
    int lat, bc;
    a[0] = 63'h4_0000_0000_0000;  b[0] = 24'd1; eq[0] = QMAX; er[0] = 25'd0;     eo[0] = 1'b1;
    a[1] = -63'sh4_0000_0000_0000; b[1] = 24'd3; eq[1] = QMIN; er[1] = -25'sd1; eo[1] = 1'b1;
    a[2] = 63'h80_0000_0000;      b[2] = 24'd1; eq[2] = QMAX; er[2] = 25'd0;     eo[2] = 1'b1;
    a[3] = 63'h7F_FFFF_FFFF;      b[3] = 24'd1; eq[3] = QMAX; er[3] = 25'd0;     eo[3] = 1'b0;
    a[4] = -63'sh80_0000_0000;    b[4] = 24'd1; eq[4] = QMIN; er[4] = 25'd0;     eo[4] = 1'b0;
    a[5] = -63'sh80_0000_0001;    b[5] = 24'd1; eq[5] = QMIN; er[5] = 25'd0;     eo[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(a[i], b[i], 1000, 0, -1, lat, bc);
      checks++;
      if (dout !== eq[i] || rem !== er[i] || ovf !== eo[i] || div0 !== 1'b0) begin
        errors++;
        $display("FAIL ovf_vec%0d: dout=%h rem=%h ovf=%b div0=%b want %h %h %b 0",
                 i, dout, rem, ovf, div0, eq[i], er[i], eo[i]);
      end
    end
  endtask

  task automatic test_div0_and_zero;
    int lat, bc;
    run_op(-63'sd5, 24'd0, 1000, 0, -1, lat, bc);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL div0_latency: got %0d want 65", lat); end
    checks++;
    if (div0 !== 1'b1 || ovf !== 1'b0 || dout !== QMIN || rem !== 25'd0) begin
      errors++; $display("FAIL div0_neg: div0=%b ovf=%b dout=%h rem=%h want 1 0 %h 0", div0, ovf, dout, rem, QMIN);
    end
    run_op(63'd5, 24'd0, 1000, 0, -1, lat, bc);
    checks++;
    if (div0 !== 1'b1 || ovf !== 1'b0 || dout !== QMAX || rem !== 25'd0) begin
      errors++; $display("FAIL div0_pos: div0=%b ovf=%b dout=%h rem=%h want 1 0 %h 0", div0, ovf, dout, rem, QMAX);
    end
    run_op(63'd0, 24'd9, 1000, 0, -1, lat, bc);
    checks++;
    if (div0 !== 1'b0 || ovf !== 1'b0 || dout !== 40'd0 || rem !== 25'd0) begin
      errors++; $display("FAIL zero_dividend: div0=%b ovf=%b dout=%h rem=%h want all 0", div0, ovf, dout, rem);
    end
  endtask

  task automatic test_stall;
    int lat, bc;
    run_op(63'd1000, 24'd7, 20, 10, -1, lat, bc);
    checks++;
    if (lat !== 75) begin errors++; $display("FAIL stall_latency: got %0d want 75", lat); end
    checks++;
    if (dout !== 40'd142 || rem !== 25'd6) begin
      errors++; $display("FAIL stall_result: dout=%0d rem=%0d want 142 6", dout, rem);
    end
  endtask

  task automatic test_ce_hold_done;
    int lat, bc;
    run_op(63'd100, 24'd9, 1000, 0, -1, lat, bc);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || dout !== 40'd11 || rem !== 25'd1) begin
      errors++; $display("FAIL ce_hold_done: done=%b dout=%0d rem=%0d want 1 11 1", done, dout, rem);
    end
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || dout !== 40'd11) begin
      errors++; $display("FAIL ce_release_done: done=%b dout=%0d want 0 11", done, dout);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    run_op(63'd1000, 24'd7, 1000, 0, 10, lat, bc);
    checks++;
    if (lat !== 65 || dout !== 40'd142 || rem !== 25'd6) begin
      errors++; $display("FAIL ignore_start: lat=%0d dout=%0d rem=%0d want 65 142 6", lat, dout, rem);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    din0 = 63'd1000; din1 = 24'd7; start = 1'b1; ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, div0, ovf} !== 4'b0000 || dout !== 40'd0 || rem !== 25'd0) begin
      errors++; $display("FAIL reset_mid_outputs: busy=%b done=%b dout=%h rem=%h want all 0", busy, done, dout, rem);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_abort: busy/done seen %0d cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative_back_to_back();
    test_overflow();
    test_div0_and_zero();
    test_stall();
    test_ce_hold_done();
    test_ignore_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
